// File: rtl/serializer_pkg.sv
// Shared parameters and FSM state type for the byte serializer.
package serializer_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BIT_HI = 2'd1,
    BIT_LO = 2'd2
  } ser_state_e;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte buffer with occupancy count; pointers wrap modulo FIFO_DEPTH.
module byte_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Explicit wrap keeps non-power-of-two depths correct.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serializer.sv
// Buffered parallel-to-serial converter: each byte goes out MSB first as
// eight strobe/data pairs, two cycles per bit, back-to-back when data waits.
module serializer
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_W     = serializer_pkg::DATA_W,
  parameter int unsigned FIFO_DEPTH = serializer_pkg::FIFO_DEPTH,
  localparam int unsigned CNT_W     = cnt_width(FIFO_DEPTH),
  localparam int unsigned BIT_W     = $clog2(DATA_W)
) (
  input  logic              clock_100,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              rx_ready_in,
  output logic              data_out,
  output logic              write_out,
  output logic              busy_out,
  output logic [CNT_W-1:0]  fifo_count
);

  ser_state_e        r_state;
  ser_state_e        w_state_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [BIT_W-1:0]  r_bit;
  logic [BIT_W-1:0]  w_bit_next;
  logic              r_data;
  logic              w_data_next;
  logic              r_write;
  logic              w_write_next;
  logic              w_pop;
  logic              w_start;
  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;

  byte_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) u_fifo (
    .i_clk   (clock_100),
    .i_rst_n (reset),
    .i_push  (valid_in),
    .i_data  (data_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign ready_out = !w_full;
  assign busy_out  = (r_state != IDLE);
  assign data_out  = r_data;
  assign write_out = r_write;

  // rx_ready_in only matters here, at a byte boundary.
  assign w_start = !w_empty && rx_ready_in;

  // Output flops take the value of the state being entered, so write_out
  // and data_out line up with BIT_HI without a combinational decode.
  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit;
    w_data_next  = r_data;
    w_write_next = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_next = BIT_HI;
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_bit_next   = '0;
          w_write_next = 1'b1;
          w_data_next  = w_head[DATA_W-1];
        end
      end
      BIT_HI: begin
        w_state_next = BIT_LO;
      end
      BIT_LO: begin
        w_shift_next = r_shift << 1;
        w_bit_next   = r_bit + 1'b1;
        if (r_bit < BIT_W'(DATA_W - 1)) begin
          w_state_next = BIT_HI;
          w_write_next = 1'b1;
          w_data_next  = r_shift[DATA_W-2];
        end else if (w_start) begin
          w_state_next = BIT_HI;
          w_pop        = 1'b1;
          w_shift_next = w_head;
          w_bit_next   = '0;
          w_write_next = 1'b1;
          w_data_next  = w_head[DATA_W-1];
        end else begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_100 or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_data  <= 1'b0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_shift <= w_shift_next;
      r_bit   <= w_bit_next;
      r_data  <= w_data_next;
      r_write <= w_write_next;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: a receiver model rebuilds bytes from the
// strobe/data pairs and compares them with the bytes accepted by the driver.
module tb_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       valid_in = 1'b0;
  logic       rx_ready = 1'b0;
  logic       ready_out;
  logic       data_out;
  logic       write_out;
  logic       busy_out;
  logic [2:0] fifo_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_push_cyc = 0;
  int busy_cyc = 0;
  int rx_count = 0;
  int rx_nbits = 0;
  logic [7:0] rx_sh = '0;
  logic prev_wr = 1'b0;
  logic [7:0] exp_q[$];
  int pulse_log[$];
  logic bit_log[$];

  serializer #(
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clock_100   (clk),
    .reset       (rst_n),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .rx_ready_in (rx_ready),
    .data_out    (data_out),
    .write_out   (write_out),
    .busy_out    (busy_out),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Receiver model and protocol invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_nbits = 0;
      prev_wr  = 1'b0;
    end else begin
      check("no_adjacent_pulses", longint'(write_out && prev_wr), 0);
      check("ready_vs_count", longint'(ready_out), longint'(fifo_count < 3'd4));
      if (busy_out) busy_cyc++;
      if (write_out) begin
        check("busy_during_pulse", longint'(busy_out), 1);
        pulse_log.push_back(cyc);
        bit_log.push_back(data_out);
        rx_sh = {rx_sh[6:0], data_out};
        rx_nbits++;
        if (rx_nbits == 8) begin
          rx_nbits = 0;
          rx_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", longint'(rx_sh), -1);
          end else begin
            check("rx_byte", longint'(rx_sh), longint'(exp_q.pop_front()));
          end
        end
      end
      prev_wr = write_out;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b, input int max_wait);
    bit done;
    done = 1'b0;
    data_in  = b;
    valid_in = 1'b1;
    for (int w = 0; w <= max_wait && !done; w++) begin
      if (ready_out) begin
        last_push_cyc = cyc + 1;
        @(posedge clk);
        exp_q.push_back(b);
        done = 1'b1;
      end else begin
        @(posedge clk);
      end
      tick();
    end
    valid_in = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic drain(input int max_cyc);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || busy_out) && w < max_cyc) begin
      tick();
      w++;
    end
    check("drain_done", longint'(exp_q.size() == 0 && !busy_out), 1);
  endtask

  task automatic check_spacing(input string name, input int n_exp, input int first_exp);
    check({name, "_pulses"}, pulse_log.size(), n_exp);
    if (pulse_log.size() == n_exp) begin
      check({name, "_first"}, pulse_log[0], first_exp);
      for (int i = 1; i < n_exp; i++) begin
        check({name, "_spacing"}, pulse_log[i] - pulse_log[i-1], 2);
      end
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] loop_bytes [4];
    int base;
    bit rnd_done;

    loop_bytes[0] = 8'h00; loop_bytes[1] = 8'hAD;
    loop_bytes[2] = 8'hFF; loop_bytes[3] = 8'h5A;

    // Reset state
    repeat (3) tick();
    check("rst_write_out", write_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", ready_out, 1);
    rst_n = 1'b1;
    tick();

    // Single byte 0xAD: latency, alternate-cycle pulses, bit order, 16 cycles
    rx_ready = 1'b1;
    pulse_log.delete(); bit_log.delete(); busy_cyc = 0;
    push_byte(8'hAD, 4);
    base = last_push_cyc;
    drain(100);
    check_spacing("ad", 8, base + 1);
    pat = 8'hAD;
    if (bit_log.size() == 8) begin
      for (int i = 0; i < 8; i++) check("ad_bit", bit_log[i], pat[7-i]);
    end
    check("ad_busy_cycles", busy_cyc, 16);
    check("ad_idle", busy_out, 0);

    // Three bytes back to back: 48 busy cycles, 24 evenly spaced pulses
    repeat (3) tick();
    pulse_log.delete(); busy_cyc = 0;
    push_byte(8'hAD, 4);
    base = last_push_cyc;
    push_byte(8'h3C, 4);
    push_byte(8'hFF, 4);
    drain(200);
    check_spacing("b2b", 24, base + 1);
    check("b2b_busy_cycles", busy_cyc, 48);

    // Receiver not ready: four accepted, fifth held until a pop frees a slot
    repeat (3) tick();
    rx_ready = 1'b0;
    pulse_log.delete();
    push_byte(8'h11, 4);
    push_byte(8'h22, 4);
    push_byte(8'h33, 4);
    push_byte(8'h44, 4);
    data_in = 8'h55; valid_in = 1'b1;
    repeat (4) tick();
    check("full_ready", ready_out, 0);
    check("full_count", fifo_count, 4);
    check("full_no_pulse", pulse_log.size(), 0);
    rx_ready = 1'b1;
    tick();
    check("pop_raises_ready", ready_out, 1);
    check("pop_count", fifo_count, 3);
    check("pop_first_pulse", write_out, 1);
    push_byte(8'h55, 4);
    check("refill_count", fifo_count, 4);
    drain(300);

    // Push and pop on the same edge at count 2
    repeat (3) tick();
    rx_ready = 1'b0;
    base = rx_count;
    push_byte(8'hA1, 4);
    push_byte(8'hB2, 4);
    check("pp_count_before", fifo_count, 2);
    rx_ready = 1'b1;
    push_byte(8'hC3, 4);
    check("pp_count_after", fifo_count, 2);
    drain(200);
    check("pp_bytes", rx_count - base, 3);

    // Reset after the third pulse of 0xAD, with a second byte still queued
    repeat (3) tick();
    pulse_log.delete();
    push_byte(8'hAD, 4);
    push_byte(8'h3C, 4);
    for (int w = 0; w < 40 && pulse_log.size() < 3; w++) tick();
    check("rst_mid_reached", pulse_log.size(), 3);
    check("rst_mid_data_before", data_out, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_write_out", write_out, 0);
    check("rst_mid_data_out", data_out, 0);
    check("rst_mid_busy", busy_out, 0);
    check("rst_mid_count", fifo_count, 0);
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    pulse_log.delete();
    repeat (24) tick();
    check("rst_mid_no_pulse", pulse_log.size(), 0);
    check("rst_mid_ready", ready_out, 1);
    check("rst_mid_count_after", fifo_count, 0);

    // Loopback with one-byte handshake per transfer
    rx_ready = 1'b0;
    base = rx_count;
    for (int i = 0; i < 4; i++) push_byte(loop_bytes[i], 4);
    for (int i = 0; i < 4; i++) begin
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("lb_started", busy_out, 1);
      check("lb_count", fifo_count, 3 - i);
      for (int w = 0; w < 40 && rx_count < base + i + 1; w++) tick();
      check("lb_received", rx_count - base, i + 1);
      repeat (3) tick();
    end
    check("lb_idle", busy_out, 0);

    // Randomised traffic with a flickering receiver-ready
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          push_byte(8'($urandom), 400);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rx_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
    join
    rx_ready = 1'b1;
    drain(1500);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_rx_partial", rx_nbits, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  DATA_W      8   byte width
  FIFO_DEPTH  4   input byte buffer depth
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clock_100    input   1       single clock; all logic on its rising edge
  reset        input   1       asynchronous, active-low reset
  data_in      input   DATA_W  parallel byte to transmit
  valid_in     input   1       data_in valid
  ready_out    output  1       buffer can accept a byte (count < FIFO_DEPTH)
  rx_ready_in  input   1       receiving deserializer can take a new byte
  data_out     output  1       serial bit to the deserializer's data_in
  write_out    output  1       bit strobe to the deserializer's write_in
  busy_out     output  1       a byte is being shifted out
  fifo_count   output  3       bytes currently buffered (0..FIFO_DEPTH)

Function
REQ-003 A push SHALL occur on a rising edge where valid_in=1 and ready_out=1; valid_in with ready_out=0 SHALL be ignored, and the producer holds its byte.
REQ-004 ready_out SHALL be combinational: 1 iff fifo_count < FIFO_DEPTH.
REQ-005 Bytes SHALL be transmitted in push order, MSB first.
REQ-006 The FSM SHALL have the states IDLE, BIT_HI and BIT_LO.
REQ-007 IDLE -> BIT_HI SHALL occur when fifo_count > 0 and rx_ready_in=1; on that edge the head byte is popped into the shift register and the bit counter is cleared.
REQ-008 In BIT_HI, write_out SHALL be 1 and data_out SHALL be the shift register MSB; the next state is always BIT_LO.
REQ-009 In BIT_LO, write_out SHALL be 0 and data_out SHALL hold its value; the shift register then shifts left and the bit counter increments.
REQ-010 BIT_LO -> BIT_HI SHALL occur when the bit counter < 7.
REQ-011 After the 8th bit, BIT_LO SHALL go to BIT_HI with a new pop when fifo_count > 0 and rx_ready_in=1, and to IDLE otherwise.
REQ-012 Each byte SHALL take exactly 16 cycles; back-to-back bytes SHALL have no idle gap.
REQ-013 data_out and write_out SHALL be registered outputs.
REQ-014 Latency: a byte pushed at edge k into an empty buffer while IDLE with rx_ready_in=1 SHALL give write_out=1 in the cycle after edge k+1.
REQ-015 rx_ready_in SHALL be sampled only at byte start; deasserting it mid-byte SHALL NOT stall the current byte.
REQ-016 A push and a pop on the same edge SHALL leave fifo_count unchanged and SHALL be legal at any count from 1 to FIFO_DEPTH-1.
REQ-017 When full, a pop SHALL raise ready_out in the following cycle.
REQ-018 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 busy_out SHALL be 1 iff the state is BIT_HI or BIT_LO.

Reset
REQ-020 While reset=0, the block SHALL asynchronously clear: state to IDLE, data_out=0, write_out=0, busy_out=0, fifo_count=0, pointers, shift register and bit counter.
REQ-021 A reset mid-byte SHALL abort the byte, and no further write_out pulse SHALL occur.
REQ-022 After reset release, ready_out SHALL be 1 and buffered bytes SHALL be discarded.

Structure
REQ-023 serializer_pkg SHALL hold DATA_W, FIFO_DEPTH and the FSM state enum type.
REQ-024 The buffer SHALL be a sub-module, byte_fifo, with push, pop, full, empty and count.
REQ-025 serializer SHALL contain the FSM, the shift register and the bit counter.

Verification
REQ-026 The bench SHALL cover these directed scenarios, one per line:
  Push 0xAD while IDLE -> write_out pulses on alternate cycles; data_out at the pulses = 1,0,1,0,1,1,0,1; then IDLE.
  Push 0xAD, 0x3C, 0xFF back-to-back -> 48 contiguous cycles, 24 pulses, correct order, no gap.
  Push 5 bytes with rx_ready_in=0 -> 4 accepted; ready_out=0; 5th held; no write_out until rx_ready_in=1.
  Push on the same edge as a pop at count=2 -> count stays 2; no byte lost or duplicated.
  reset=0 after the 3rd pulse of 0xAD -> outputs 0 immediately; no further pulses; fifo_count=0.
  Loopback into the deserializer with ack after each byte -> received bytes equal the sent sequence 0x00, 0xAD, 0xFF, 0x5A.
